// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type plus instruction-cache frame layout
// for the default 16-frame direct-mapped icache.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;
    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped frame store with one write port and one
// combinational read port; only the valid bits are reset.
module icache_array import cpu_types_pkg::*; #(
    parameter int ISETS = 16,
    parameter int IDX_W = $clog2(ISETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output word_t            rdata
);
    logic [ISETS-1:0] valid;
    logic [TAG_W-1:0] tag_mem [ISETS];
    word_t            data_mem [ISETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            valid <= '0;
        else if (wen)
            valid[widx] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wen) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tag_mem[ridx];
    assign rdata  = data_mem[ridx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache; misses go
// through a single FILL state that reads one word from memory.
module icache import cpu_types_pkg::*; #(
    parameter int ISETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);
    localparam int IDX_W = $clog2(ISETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_state_t;

    icache_state_t    state;
    logic [29:0]      miss_word;
    logic             frame_valid;
    logic [TAG_W-1:0] frame_tag;
    word_t            frame_data;
    logic             hit;
    logic             addr_unused;

    assign addr_unused = &{1'b0, imemaddr[1:0]};

    // Hits are only honoured in IDLE; the fill cycle never forwards iload.
    assign hit      = state == IDLE && imemREN && frame_valid && frame_tag == imemaddr[31:IDX_W+2];
    assign ihit     = hit;
    assign imemload = hit ? frame_data : '0;
    assign iREN     = state == FILL;
    assign iaddr    = iREN ? {miss_word, 2'b00} : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_word <= '0;
        end else if (state == IDLE) begin
            if (imemREN && !hit) begin
                state     <= FILL;
                miss_word <= imemaddr[31:2];
            end
        end else if (!iwait) begin
            state <= IDLE;
        end
    end

    icache_array #(.ISETS(ISETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .CLK    (CLK),
        .nRST   (nRST),
        .wen    (iREN && !iwait),
        .widx   (miss_word[IDX_W-1:0]),
        .wtag   (miss_word[29:IDX_W]),
        .wdata  (iload),
        .ridx   (imemaddr[IDX_W+1:2]),
        .rvalid (frame_valid),
        .rtag   (frame_tag),
        .rdata  (frame_data)
    );
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus random accesses checked against a
// word-address-per-frame model of a 16-frame direct-mapped cache.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    int n_assert = 0;
    int n_fail   = 0;

    bit    m_valid [16];
    word_t m_addr  [16];
    word_t m_data  [16];

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    function automatic bit model_hit(input word_t a);
        return m_valid[a[5:2]] && m_addr[a[5:2]] == {a[31:2], 2'b00};
    endfunction

    // One complete read of address a; on a miss the memory stalls for
    // `waits` cycles while imemaddr wanders to alt, then returns d.
    task automatic access(input word_t a, input word_t d, input int waits, input word_t alt);
        word_t wa;
        wa = {a[31:2], 2'b00};
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = '0;
        #1;
        if (model_hit(a)) begin
            chk("hit_ihit", ihit, 1);
            chk("hit_data", imemload, m_data[a[5:2]]);
            chk("hit_iren", iREN, 0);
            tick();
        end else begin
            chk("miss_ihit", ihit, 0);
            chk("miss_load", imemload, 0);
            chk("miss_iren", iREN, 0);
            tick();
            for (int w = 0; w < waits; w++) begin
                imemaddr = alt; imemREN = 1'($urandom); iwait = 1'b1;
                #1;
                chk("wait_iren", iREN, 1);
                chk("wait_iaddr", iaddr, wa);
                chk("wait_ihit", ihit, 0);
                tick();
            end
            iwait = 1'b0; iload = d;
            #1;
            chk("fill_iren", iREN, 1);
            chk("fill_iaddr", iaddr, wa);
            chk("fill_ihit", ihit, 0);
            tick();
            m_valid[a[5:2]] = 1'b1; m_addr[a[5:2]] = wa; m_data[a[5:2]] = d;
            iwait = 1'b1; iload = '0; imemREN = 1'b1; imemaddr = a;
            #1;
            chk("after_ihit", ihit, 1);
            chk("after_data", imemload, d);
            chk("after_iren", iREN, 0);
            tick();
        end
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b1; imemaddr = '0; iwait = 1'b1; iload = '0;
        model_clear();
        #2;
        chk("rst_ihit", ihit, 0);
        chk("rst_iren", iREN, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_load", imemload, 0);
        tick();
        nRST = 1'b1;

        access(32'h0000_0000, 32'h2001_0005, 3, 32'h0000_0000);
        access(32'h0000_0000, 32'h0, 0, 32'h0);
        access(32'h0000_0003, 32'h0, 0, 32'h0);

        access(32'h0000_0040, 32'h8C22_0000, 1, 32'h0000_0040);
        imemREN = 1'b1; imemaddr = 32'h0000_0000;
        #1;
        chk("evict_miss", ihit, 0);
        access(32'h0000_0000, 32'h2001_0005, 0, 32'h0);

        access(32'h0000_0010, 32'h1111_2222, 2, 32'h0000_0020);
        access(32'h0000_0020, 32'h3333_4444, 1, 32'h0000_0020);

        imemREN = 1'b1; imemaddr = 32'h0000_0004; iwait = 1'b1;
        #1;
        chk("pre_rst_miss", ihit, 0);
        tick();
        chk("pre_rst_iren", iREN, 1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_iren", iREN, 0);
        chk("mid_rst_iaddr", iaddr, 0);
        tick();
        nRST = 1'b1;
        model_clear();
        access(32'h0000_0004, 32'hABCD_0004, 1, 32'h0000_0004);
        access(32'h0000_0000, 32'h2001_0005, 0, 32'h0);

        imemaddr = 32'h0000_0000;
        for (int c = 0; c < 5; c++) begin
            imemREN = 1'b0;
            #1;
            chk("noren_ihit", ihit, 0);
            chk("noren_iren", iREN, 0);
            tick();
        end
        imemREN = 1'b1;
        #1;
        chk("noren_then_hit", ihit, 1);
        tick();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                imemREN = 1'b0; imemaddr = $urandom & 32'hFF;
                #1;
                chk("rnd_idle_ihit", ihit, 0);
                chk("rnd_idle_iren", iREN, 0);
                tick();
            end else begin
                access($urandom & 32'hFF, $urandom, $urandom_range(0, 3), $urandom & 32'hFF);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
